// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter
//   Round-robin arbiter for 16 requesters sharing one resource. It produces
//   a 4-bit winner index and a one-hot grant vector, which is the decode of
//   gnt_idx while gnt_valid is high and all-zero otherwise. A grant is held
//   while its owner keeps requesting. The search pointer always sits one past
//   the most recent winner, so that winner has the lowest priority at the
//   next arbitration.
//
//   Optional feature (macro ARB_HOLD_LIMIT_EN): caps the length of a grant at
//   MAX_HOLD consecutive cycles (legal 1..15) when other requests are waiting.
//   Without the macro the grant is held indefinitely and MAX_HOLD is unused.
//
// Ports
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   en_in       in   1   global arbiter enable
//   req         in  16   level-sensitive request lines
//   gnt         out 16   registered one-hot grant
//   gnt_idx     out  4   index of current / last winner
//   gnt_valid   out  1   a grant is active
//   dbg_state_o out  1   FSM state (0 = IDLE, 1 = GRANT)
//
// Handshake: a requester owns the resource for every cycle in which its gnt
// bit is high; it releases by dropping req, and the next owner's gnt is valid
// after the following edge with no idle cycle in between.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_in,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        dbg_state_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  ptr_q;
  logic [3:0]  gnt_idx_q;
  logic        gnt_valid_q;
  logic [15:0] gnt_q;

  // Round-robin search starting at ptr_q with modulo-16 wrap.
  logic       found;
  logic [3:0] win;
  logic [3:0] cand;

  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < 16; k++) begin
      cand = ptr_q + 4'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  logic [3:0] hold_cnt_q;
  logic       other_pending;
  logic       hold_expired;

  // gnt_q is the decode of the current winner while in GRANT.
  assign other_pending = |(req & ~gnt_q);
  assign hold_expired  = (hold_cnt_q == 4'(MAX_HOLD));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 4'd0;
      gnt_idx_q   <= 4'd0;
      gnt_valid_q <= 1'b0;
      gnt_q       <= 16'd0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q  <= 4'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (en_in && found) begin
            state_q     <= GRANT;
            gnt_idx_q   <= win;
            gnt_valid_q <= 1'b1;
            gnt_q       <= 16'd1 << win;
            ptr_q       <= win + 4'd1;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q  <= 4'd1;
`endif
          end
        end
        GRANT: begin
          if (!en_in) begin
            // gnt_idx and ptr are retained for the next enable.
            state_q     <= IDLE;
            gnt_valid_q <= 1'b0;
            gnt_q       <= 16'd0;
          end else if (!req[gnt_idx_q]) begin
            if (found) begin
              // Zero-bubble handoff; the released owner cannot win because
              // ptr_q already points past it and its request is low.
              gnt_idx_q   <= win;
              gnt_q       <= 16'd1 << win;
              ptr_q       <= win + 4'd1;
`ifdef ARB_HOLD_LIMIT_EN
              hold_cnt_q  <= 4'd1;
`endif
            end else begin
              state_q     <= IDLE;
              gnt_valid_q <= 1'b0;
              gnt_q       <= 16'd0;
            end
          end
`ifdef ARB_HOLD_LIMIT_EN
          else if (hold_expired && other_pending) begin
            // Forced handoff: the search reaches the current owner last, so
            // a different requester is always chosen here.
            gnt_idx_q  <= win;
            gnt_q      <= 16'd1 << win;
            ptr_q      <= win + 4'd1;
            hold_cnt_q <= 4'd1;
          end else if (!hold_expired) begin
            hold_cnt_q <= hold_cnt_q + 4'd1;
          end
`endif
        end
        default: begin
          state_q     <= IDLE;
          gnt_valid_q <= 1'b0;
          gnt_q       <= 16'd0;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign gnt_idx     = gnt_idx_q;
  assign gnt_valid   = gnt_valid_q;
  assign dbg_state_o = state_q;

endmodule
